// File: rtl/definitions.sv
// Shared ALU typedefs: opcodes, instruction word and issue-queue FSM states.
package definitions;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_MUL_WAIT = 2'd2
  } iq_state_t;

  // Encoding 3 is unassigned and must never reach the ALU.
  function automatic logic is_legal_op(input opcode_t op);
    return (op == ADD) || (op == SUB) || (op == MUL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; occupancy is tracked separately
// from the pointers so that full and empty can be told apart.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            w_doPush;
  logic            w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage array: data only, no reset needed since the pointers gate reads.
  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally; count moves only when exactly one side is active.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers decoded instructions and issues them to the ALU one per cycle,
// inserting bubbles after each MUL and dropping undefined opcodes.
module alu_issue_queue
  import definitions::*;
#(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  instruction_t               in_iw,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  output instruction_t               IW,
  output logic                       iw_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal_op,
  output logic [15:0]                issued_cnt
);

  localparam int         CW        = $clog2(DEPTH+1);
  localparam logic [2:0] WAIT_INIT = 3'(MUL_LAT - 1);

  iq_state_t    r_state;
  logic [2:0]   r_waitCnt;
  instruction_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_issue;
  logic         w_drop;
  logic         w_emptyNext;

  // Full means count has reached DEPTH, so this is count < DEPTH from registers.
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;

  // A head slot is consumed whenever issue is allowed; illegal ones are dropped.
  assign w_pop   = (r_state != S_MUL_WAIT) && !w_empty && !hold;
  assign w_issue = w_pop && is_legal_op(w_head.opcode);
  assign w_drop  = w_pop && !is_legal_op(w_head.opcode);

  assign w_emptyNext = w_empty ? !w_push
                               : ((count == CW'(1)) && w_pop && !w_push);

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (instruction_t)
  ) u_fifo (
    .clock   (clock),
    .resetN  (resetN),
    .i_push  (w_push),
    .i_data  (in_iw),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Issue FSM: loads IW, pulses iw_valid, and counts down the MUL bubble.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_waitCnt  <= '0;
      IW         <= '0;
      iw_valid   <= 1'b0;
      illegal_op <= 1'b0;
      issued_cnt <= '0;
    end else begin
      iw_valid <= 1'b0;
      if (w_drop) illegal_op <= 1'b1;
      case (r_state)
        S_IDLE, S_ISSUE: begin
          if (w_issue) begin
            IW         <= w_head;
            iw_valid   <= 1'b1;
            issued_cnt <= issued_cnt + 16'd1;
          end
          if (w_issue && (w_head.opcode == MUL) && (MUL_LAT > 1)) begin
            r_state   <= S_MUL_WAIT;
            r_waitCnt <= WAIT_INIT;
          end else begin
            r_state <= w_emptyNext ? S_IDLE : S_ISSUE;
          end
        end
        S_MUL_WAIT: begin
          r_waitCnt <= r_waitCnt - 3'd1;
          if (r_waitCnt <= 3'd1) r_state <= w_emptyNext ? S_IDLE : S_ISSUE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: the driver queues expected issues,
// a monitor pops and compares on every iw_valid, and directed checks cover
// cycle timing, backpressure, illegal drops, reset and counter wrap.
module tb_alu_issue_queue;
  import definitions::*;

  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;

  logic                       clock  = 1'b0;
  logic                       resetN = 1'b1;
  instruction_t               in_iw;
  logic                       in_valid;
  logic                       in_ready;
  logic                       hold;
  instruction_t               IW;
  logic                       iw_valid;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       illegal_op;
  logic [15:0]                issued_cnt;

  int compared   = 0;
  int mismatched = 0;
  instruction_t expQ [$];

  always #5 clock = ~clock;

  alu_issue_queue #(
    .DEPTH   (DEPTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .in_iw      (in_iw),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .IW         (IW),
    .iw_valid   (iw_valid),
    .count      (count),
    .illegal_op (illegal_op),
    .issued_cnt (issued_cnt)
  );

  task automatic checkOutput(input string name, input logic [65:0] actual,
                             input logic [65:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic instruction_t mk(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    instruction_t t;
    t.opcode = opcode_t'(op);
    t.a      = a;
    t.b      = b;
    return t;
  endfunction

  // Offer one instruction, wait (bounded) for acceptance, and queue the
  // expected issue when the opcode is legal.
  task automatic applyStimulus(input instruction_t ins, input bit legal);
    int waited = 0;
    in_iw    = ins;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL push_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (legal) expQ.push_back(ins);
  endtask

  task automatic resetDut();
    @(negedge clock);
    resetN   = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    expQ.delete();
    tick();
    @(negedge clock);
    resetN = 1'b1;
    tick();
  endtask

  // Monitor: every issued instruction must match the oldest expected entry.
  initial begin
    instruction_t e;
    forever begin
      @(negedge clock);
      if (resetN && iw_valid) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_issue: got IW=0x%0h, expected no issue", IW);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_IW", IW, e);
        end
      end
    end
  end

  initial begin
    logic exV [4];
    logic [2:0] exC [4];
    in_iw    = '0;
    in_valid = 1'b0;
    hold     = 1'b0;

    // Reset values
    #1 resetN = 1'b0;
    #1;
    checkOutput("rst_IW", IW, '0);
    checkOutput("rst_iw_valid", iw_valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_illegal", illegal_op, 0);
    checkOutput("rst_issued", issued_cnt, 0);
    @(negedge clock);
    resetN = 1'b1;
    tick();

    // Single ADD into an idle queue: one-cycle latency, one-cycle pulse
    applyStimulus(mk(2'd0, 32'd5, 32'd3), 1'b1);
    checkOutput("t1_count", count, 1);
    checkOutput("t1_valid_early", iw_valid, 0);
    tick();
    checkOutput("t1_valid", iw_valid, 1);
    checkOutput("t1_opcode", IW.opcode, 0);
    checkOutput("t1_a", IW.a, 5);
    checkOutput("t1_b", IW.b, 3);
    checkOutput("t1_issued", issued_cnt, 1);
    tick();
    checkOutput("t1_valid_pulse", iw_valid, 0);

    // MUL, ADD, SUB back-to-back: iw_valid 1,0,0,1,1 and count peaks at 2
    resetDut();
    applyStimulus(mk(2'd2, 32'd6, 32'd7), 1'b1);
    checkOutput("t2_before", iw_valid, 0);
    applyStimulus(mk(2'd0, 32'd10, 32'd20), 1'b1);
    checkOutput("t2_v0", iw_valid, 1);
    checkOutput("t2_c0", count, 1);
    applyStimulus(mk(2'd1, 32'd9, 32'd4), 1'b1);
    checkOutput("t2_v1", iw_valid, 0);
    checkOutput("t2_c1", count, 2);
    exV = '{1'b0, 1'b1, 1'b1, 1'b0};
    exC = '{3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t2_v%0d", i + 2), iw_valid, exV[i]);
      checkOutput($sformatf("t2_c%0d", i + 2), count, exC[i]);
    end
    checkOutput("t2_issued", issued_cnt, 3);

    // Backpressure under hold: four accepted, fifth refused, then drain in order
    resetDut();
    hold = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(2'(i % 2), 32'(100 + i), 32'(i)), 1'b1);
    checkOutput("t3_count_full", count, 4);
    checkOutput("t3_ready_low", in_ready, 0);
    checkOutput("t3_no_issue", iw_valid, 0);
    in_iw    = mk(2'd0, 32'd999, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("t3_fifth_refused", count, 4);
    checkOutput("t3_ready_still_low", in_ready, 0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t3_drain_v%0d", i), iw_valid, 1);
      checkOutput($sformatf("t3_drain_c%0d", i), count, 3'(3 - i));
      checkOutput($sformatf("t3_drain_rdy%0d", i), in_ready, 1);
    end
    tick();
    checkOutput("t3_drain_end", iw_valid, 0);

    // Illegal opcode between two ADDs: dropped as a bubble, sticky flag
    resetDut();
    applyStimulus(mk(2'd0, 32'd1, 32'd2), 1'b1);
    checkOutput("t4_illegal_pre", illegal_op, 0);
    applyStimulus(mk(2'd3, 32'hdead, 32'hbeef), 1'b0);
    checkOutput("t4_v0", iw_valid, 1);
    checkOutput("t4_illegal_not_yet", illegal_op, 0);
    applyStimulus(mk(2'd0, 32'd7, 32'd8), 1'b1);
    checkOutput("t4_bubble", iw_valid, 0);
    checkOutput("t4_illegal_set", illegal_op, 1);
    tick();
    checkOutput("t4_v2", iw_valid, 1);
    checkOutput("t4_IW_a", IW.a, 7);
    repeat (3) tick();
    checkOutput("t4_illegal_sticky", illegal_op, 1);
    checkOutput("t4_issued", issued_cnt, 2);
    checkOutput("t4_idle", iw_valid, 0);

    // Reset during MUL_WAIT with three entries queued
    resetDut();
    hold = 1'b1;
    applyStimulus(mk(2'd2, 32'd2, 32'd3), 1'b1);
    applyStimulus(mk(2'd0, 32'd4, 32'd5), 1'b1);
    applyStimulus(mk(2'd1, 32'd6, 32'd1), 1'b1);
    applyStimulus(mk(2'd0, 32'd8, 32'd8), 1'b1);
    hold = 1'b0;
    tick();
    checkOutput("t5_mul_issue", iw_valid, 1);
    checkOutput("t5_mul_opcode", IW.opcode, 2);
    tick();
    checkOutput("t5_waiting", iw_valid, 0);
    checkOutput("t5_count3", count, 3);
    #2;
    resetN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t5_rst_IW", IW, '0);
    checkOutput("t5_rst_valid", iw_valid, 0);
    checkOutput("t5_rst_count", count, 0);
    checkOutput("t5_rst_ready", in_ready, 1);
    checkOutput("t5_rst_issued", issued_cnt, 0);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t5_quiet_v%0d", i), iw_valid, 0);
      checkOutput($sformatf("t5_quiet_c%0d", i), count, 0);
    end

    // 65537 ADDs: issued_cnt wraps to 1
    resetDut();
    for (int i = 0; i < 65537; i++)
      applyStimulus(mk(2'd0, 32'(i), ~32'(i)), 1'b1);
    tick();
    tick();
    checkOutput("t6_wrap", issued_cnt, 1);
    checkOutput("t6_idle", iw_valid, 0);

    checkOutput("sb_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
